// File: rtl/axil_apb_bridge.sv
// AXI4-Lite slave to APB master bridge.
// One transaction in flight at a time; contended read/write requests are
// served round-robin; an optional PREADY timeout aborts hung peripherals.
module axil_apb_bridge #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 0
) (
    input  logic                    AXI_PCLK,
    input  logic                    AXI_PRESET,
    input  logic [ADDR_WIDTH-1:0]   AXI4Lite_AWADDR,
    input  logic [2:0]              AXI4Lite_AWPROT,
    input  logic                    AXI4Lite_AWVALID,
    output logic                    AXI4Lite_AWREADY,
    input  logic [DATA_WIDTH-1:0]   AXI4Lite_WDATA,
    input  logic [DATA_WIDTH/8-1:0] AXI4Lite_WSTRB,
    input  logic                    AXI4Lite_WVALID,
    output logic                    AXI4Lite_WREADY,
    output logic [1:0]              AXI4Lite_BRESP,
    output logic                    AXI4Lite_BVALID,
    input  logic                    AXI4Lite_BREADY,
    input  logic [ADDR_WIDTH-1:0]   AXI4Lite_ARADDR,
    input  logic [2:0]              AXI4Lite_ARPROT,
    input  logic                    AXI4Lite_ARVALID,
    output logic                    AXI4Lite_ARREADY,
    output logic [DATA_WIDTH-1:0]   AXI4Lite_RDATA,
    output logic [1:0]              AXI4Lite_RRESP,
    output logic                    AXI4Lite_RVALID,
    input  logic                    AXI4Lite_RREADY,
    output logic [ADDR_WIDTH-1:0]   APB_paddr,
    output logic [DATA_WIDTH-1:0]   APB_pwdata,
    input  logic [DATA_WIDTH-1:0]   APB_prdata,
    output logic                    APB_psel,
    output logic                    APB_penable,
    output logic                    APB_pwrite,
    output logic [3:0]              APB_pstb,
    input  logic                    APB_pready,
    input  logic                    APB_pslverr
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned CNT_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t                 state_q, state_d;
    logic                   op_wr_q, op_wr_d;       // 1: current op is a write
    logic                   last_wr_q, last_wr_d;   // winner of the last contention
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   timeout_c;
    logic [1:0]             resp_c;

    logic                   aw_full_q, aw_full_d;
    logic                   w_full_q, w_full_d;
    logic                   ar_full_q, ar_full_d;
    logic [ADDR_WIDTH-1:0]  awaddr_q, araddr_q;
    logic [DATA_WIDTH-1:0]  wdata_q;
    logic [STRB_W-1:0]      wstrb_q;

    logic                   awready_q, awready_d;
    logic                   wready_q, wready_d;
    logic                   arready_q, arready_d;
    logic                   bvalid_q, bvalid_d;
    logic [1:0]             bresp_q, bresp_d;
    logic                   rvalid_q, rvalid_d;
    logic [1:0]             rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic [ADDR_WIDTH-1:0]  paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0]  pwdata_q, pwdata_d;
    logic                   psel_q, psel_d;
    logic                   penable_q, penable_d;
    logic                   pwrite_q, pwrite_d;
    logic [3:0]             pstb_q, pstb_d;

    logic aw_hs, w_hs, ar_hs, b_hs, r_hs;
    logic wr_pend, rd_pend;
    logic unused_prot;

    assign unused_prot = ^{AXI4Lite_AWPROT, AXI4Lite_ARPROT};

    assign aw_hs   = AXI4Lite_AWVALID & awready_q;
    assign w_hs    = AXI4Lite_WVALID  & wready_q;
    assign ar_hs   = AXI4Lite_ARVALID & arready_q;
    assign b_hs    = bvalid_q & AXI4Lite_BREADY;
    assign r_hs    = rvalid_q & AXI4Lite_RREADY;
    assign wr_pend = aw_full_q & w_full_q;
    assign rd_pend = ar_full_q;

    // Channel buffer occupancy: fill on handshake, free on the response handshake
    always_comb begin
        aw_full_d = aw_full_q;
        w_full_d  = w_full_q;
        ar_full_d = ar_full_q;
        if (aw_hs) aw_full_d = 1'b1;
        if (w_hs)  w_full_d  = 1'b1;
        if (ar_hs) ar_full_d = 1'b1;
        if (b_hs) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
        end
        if (r_hs) ar_full_d = 1'b0;
    end

    // Channel buffer registers and payload capture
    always_ff @(posedge AXI_PCLK or posedge AXI_PRESET) begin
        if (AXI_PRESET) begin
            aw_full_q <= 1'b0;
            w_full_q  <= 1'b0;
            ar_full_q <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            araddr_q  <= '0;
        end else begin
            aw_full_q <= aw_full_d;
            w_full_q  <= w_full_d;
            ar_full_q <= ar_full_d;
            if (aw_hs) awaddr_q <= AXI4Lite_AWADDR;
            if (w_hs) begin
                wdata_q <= AXI4Lite_WDATA;
                wstrb_q <= AXI4Lite_WSTRB;
            end
            if (ar_hs) araddr_q <= AXI4Lite_ARADDR;
        end
    end

    // FSM state register with arbitration and timeout bookkeeping
    always_ff @(posedge AXI_PCLK or posedge AXI_PRESET) begin
        if (AXI_PRESET) begin
            state_q   <= IDLE;
            op_wr_q   <= 1'b0;
            last_wr_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            op_wr_q   <= op_wr_d;
            last_wr_q <= last_wr_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next-state logic; last_wr only moves when both directions contend
    always_comb begin
        state_d   = state_q;
        op_wr_d   = op_wr_q;
        last_wr_d = last_wr_q;
        cnt_d     = cnt_q;
        timeout_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr_pend && rd_pend) begin
                    op_wr_d   = ~last_wr_q;
                    last_wr_d = ~last_wr_q;
                    state_d   = SETUP;
                end else if (wr_pend) begin
                    op_wr_d = 1'b1;
                    state_d = SETUP;
                end else if (rd_pend) begin
                    op_wr_d = 1'b0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                cnt_d   = '0;
                state_d = ACCESS;
            end
            ACCESS: begin
                if (APB_pready) begin
                    state_d = RESP;
                end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
                    timeout_c = 1'b1;
                    state_d   = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (op_wr_q ? b_hs : r_hs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output next values, derived from the upcoming state so they register in step
    always_comb begin
        awready_d = ~aw_full_d;
        wready_d  = ~w_full_d;
        arready_d = ~ar_full_d;
        psel_d    = (state_d == SETUP) || (state_d == ACCESS);
        penable_d = (state_d == ACCESS);
        bvalid_d  = (state_d == RESP) && op_wr_d;
        rvalid_d  = (state_d == RESP) && !op_wr_d;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pwrite_d  = pwrite_q;
        pstb_d    = pstb_q;
        bresp_d   = bresp_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        resp_c    = timeout_c ? 2'b11 : (APB_pslverr ? 2'b10 : 2'b00);
        if ((state_q == IDLE) && (state_d == SETUP)) begin
            paddr_d  = op_wr_d ? awaddr_q : araddr_q;
            pwdata_d = op_wr_d ? wdata_q : '0;
            pwrite_d = op_wr_d;
            pstb_d   = op_wr_d ? 4'(wstrb_q) : 4'h0;
        end
        if ((state_q == ACCESS) && (state_d == RESP)) begin
            if (op_wr_q) begin
                bresp_d = resp_c;
            end else begin
                rresp_d = resp_c;
                rdata_d = timeout_c ? '0 : APB_prdata;
            end
        end
    end

    // Output registers
    always_ff @(posedge AXI_PCLK or posedge AXI_PRESET) begin
        if (AXI_PRESET) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            arready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            rvalid_q  <= 1'b0;
            rresp_q   <= 2'b00;
            rdata_q   <= '0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            pstb_q    <= 4'h0;
        end else begin
            awready_q <= awready_d;
            wready_q  <= wready_d;
            arready_q <= arready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            pstb_q    <= pstb_d;
        end
    end

    assign AXI4Lite_AWREADY = awready_q;
    assign AXI4Lite_WREADY  = wready_q;
    assign AXI4Lite_ARREADY = arready_q;
    assign AXI4Lite_BVALID  = bvalid_q;
    assign AXI4Lite_BRESP   = bresp_q;
    assign AXI4Lite_RVALID  = rvalid_q;
    assign AXI4Lite_RRESP   = rresp_q;
    assign AXI4Lite_RDATA   = rdata_q;
    assign APB_paddr        = paddr_q;
    assign APB_pwdata       = pwdata_q;
    assign APB_psel         = psel_q;
    assign APB_penable      = penable_q;
    assign APB_pwrite       = pwrite_q;
    assign APB_pstb         = pstb_q;

endmodule

// File: tb/tb_axil_apb_bridge.sv
// Bench for axil_apb_bridge: directed AXI stimulus, behavioural APB slave,
// transaction-level expectation queues checked every cycle.
`timescale 1ns/1ps
module tb_axil_apb_bridge;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] awaddr = '0;
    logic [2:0]  awprot = 3'b010;
    logic        awvalid = 1'b0, awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0, wready;
    logic [1:0]  bresp;
    logic        bvalid, bready = 1'b1;
    logic [31:0] araddr = '0;
    logic [2:0]  arprot = 3'b101;
    logic        arvalid = 1'b0, arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid, rready = 1'b1;
    logic [31:0] paddr, pwdata;
    logic [31:0] prdata = '0;
    logic        psel, penable, pwrite;
    logic [3:0]  pstb;
    logic        pready = 1'b0, pslverr = 1'b0;

    axil_apb_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TO)) dut (
        .AXI_PCLK(clk), .AXI_PRESET(rst),
        .AXI4Lite_AWADDR(awaddr), .AXI4Lite_AWPROT(awprot),
        .AXI4Lite_AWVALID(awvalid), .AXI4Lite_AWREADY(awready),
        .AXI4Lite_WDATA(wdata), .AXI4Lite_WSTRB(wstrb),
        .AXI4Lite_WVALID(wvalid), .AXI4Lite_WREADY(wready),
        .AXI4Lite_BRESP(bresp), .AXI4Lite_BVALID(bvalid), .AXI4Lite_BREADY(bready),
        .AXI4Lite_ARADDR(araddr), .AXI4Lite_ARPROT(arprot),
        .AXI4Lite_ARVALID(arvalid), .AXI4Lite_ARREADY(arready),
        .AXI4Lite_RDATA(rdata), .AXI4Lite_RRESP(rresp),
        .AXI4Lite_RVALID(rvalid), .AXI4Lite_RREADY(rready),
        .APB_paddr(paddr), .APB_pwdata(pwdata), .APB_prdata(prdata),
        .APB_psel(psel), .APB_penable(penable), .APB_pwrite(pwrite),
        .APB_pstb(pstb), .APB_pready(pready), .APB_pslverr(pslverr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Model: expected APB transfers and AXI responses, in order
    typedef struct { logic wr; logic [31:0] addr; logic [31:0] data; logic [3:0] strb; } apb_t;
    typedef struct { logic [1:0] resp; logic [31:0] data; } rsp_t;
    apb_t       exp_apb[$];
    logic [1:0] exp_b[$];
    rsp_t       exp_r[$];
    apb_t       cur;
    bit         m_last_wr = 1'b0;

    // Slave behaviour knobs: wait states before PREADY, error flag, read data
    int          slv_wait = 0;
    logic        slv_err = 1'b0;
    logic [31:0] slv_rdata = '0;
    int          acc_cnt = 0;

    function automatic logic [1:0] model_resp(input int waits, input logic err);
        if (waits >= int'(TO)) return 2'b11;
        return err ? 2'b10 : 2'b00;
    endfunction

    task automatic expect_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        apb_t t;
        t.wr = 1'b1; t.addr = a; t.data = d; t.strb = s;
        exp_apb.push_back(t);
        exp_b.push_back(model_resp(slv_wait, slv_err));
    endtask

    task automatic expect_rd(input logic [31:0] a);
        apb_t t;
        rsp_t r;
        t.wr = 1'b0; t.addr = a; t.data = '0; t.strb = 4'h0;
        exp_apb.push_back(t);
        r.resp = model_resp(slv_wait, slv_err);
        r.data = (slv_wait >= int'(TO)) ? 32'h0 : slv_rdata;
        exp_r.push_back(r);
    endtask

    task automatic flush_model();
        exp_apb.delete();
        exp_b.delete();
        exp_r.delete();
        m_last_wr = 1'b0;
    endtask

    // APB slave: PREADY after slv_wait ACCESS cycles
    always @(negedge clk) begin
        if (psel && penable) begin
            pready  = (acc_cnt == slv_wait);
            pslverr = pready ? slv_err : 1'b0;
            prdata  = pready ? slv_rdata : 32'h0;
            acc_cnt = acc_cnt + 1;
        end else begin
            acc_cnt = 0;
            pready  = 1'b0;
            pslverr = 1'b0;
            prdata  = 32'h0;
        end
    end

    // Compare process: APB transfers and AXI responses against the model
    always @(negedge clk) begin
        if (!rst) begin
            chk("penable_implies_psel", 32'(!penable || psel), 1);
            chk("b_r_exclusive", 32'(!(bvalid && rvalid)), 1);
            if (psel && !penable) begin
                chk("setup_expected", 32'(exp_apb.size() != 0), 1);
                if (exp_apb.size() != 0) begin
                    cur = exp_apb.pop_front();
                    chk("setup_pwrite", 32'(pwrite), 32'(cur.wr));
                    chk("setup_paddr", paddr, cur.addr);
                    chk("setup_pstb", 32'(pstb), 32'(cur.wr ? cur.strb : 4'h0));
                    if (cur.wr) chk("setup_pwdata", pwdata, cur.data);
                end
            end else if (psel && penable) begin
                chk("access_pwrite", 32'(pwrite), 32'(cur.wr));
                chk("access_paddr", paddr, cur.addr);
                chk("access_pstb", 32'(pstb), 32'(cur.wr ? cur.strb : 4'h0));
                if (cur.wr) chk("access_pwdata", pwdata, cur.data);
            end
            if (bvalid) begin
                chk("bvalid_expected", 32'(exp_b.size() != 0), 1);
                if (exp_b.size() != 0) chk("bresp", 32'(bresp), 32'(exp_b[0]));
            end
            if (rvalid) begin
                chk("rvalid_expected", 32'(exp_r.size() != 0), 1);
                if (exp_r.size() != 0) begin
                    chk("rresp", 32'(rresp), 32'(exp_r[0].resp));
                    chk("rdata", rdata, exp_r[0].data);
                end
            end
        end
    end

    // Retire responses on their handshake edge
    always @(posedge clk) begin
        if (!rst) begin
            if (bvalid && bready && exp_b.size() != 0) exp_b.delete(0);
            if (rvalid && rready && exp_r.size() != 0) exp_r.delete(0);
        end
    end

    function automatic bit cond(input int kind);
        case (kind)
            0:       return bvalid;
            1:       return rvalid;
            2:       return psel && penable;
            default: return awready && wready && arready && !psel && !bvalid && !rvalid;
        endcase
    endfunction

    task automatic wait_for(input string name, input int kind);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (cond(kind)) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        chk({name, "_in_time"}, 32'(ok), 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        flush_model();
        step();
        step();
        rst = 1'b0;
        step();
        chk("rel_awready", 32'(awready), 1);
        chk("rel_wready", 32'(wready), 1);
        chk("rel_arready", 32'(arready), 1);
    endtask

    task automatic both_round(input string tag, input logic [31:0] wa, input logic [31:0] wd,
                              input logic [31:0] ra, input logic first_wr);
        awaddr = wa; awvalid = 1'b1;
        wdata = wd; wstrb = 4'hF; wvalid = 1'b1;
        araddr = ra; arvalid = 1'b1;
        if (!m_last_wr) begin
            expect_wr(wa, wd, 4'hF);
            expect_rd(ra);
        end else begin
            expect_rd(ra);
            expect_wr(wa, wd, 4'hF);
        end
        m_last_wr = !m_last_wr;
        step();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        step();
        chk({tag, "_first_psel"}, 32'(psel), 1);
        chk({tag, "_first_pwrite"}, 32'(pwrite), 32'(first_wr));
        wait_for({tag, "_done"}, 3);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        step();
        chk("rst_awready", 32'(awready), 0);
        chk("rst_wready", 32'(wready), 0);
        chk("rst_arready", 32'(arready), 0);
        chk("rst_bvalid", 32'(bvalid), 0);
        chk("rst_rvalid", 32'(rvalid), 0);
        chk("rst_psel", 32'(psel), 0);
        chk("rst_penable", 32'(penable), 0);
        chk("rst_pwrite", 32'(pwrite), 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwdata", pwdata, 0);
        chk("rst_pstb", 32'(pstb), 0);
        chk("rst_rdata", rdata, 0);
        step();
        rst = 1'b0;
        step();
        chk("rel_awready", 32'(awready), 1);
        chk("rel_wready", 32'(wready), 1);
        chk("rel_arready", 32'(arready), 1);

        // Write with AW and W on the same edge, zero-wait slave
        awaddr = 32'h1000_0004; awvalid = 1'b1;
        wdata = 32'hDEAD_BEEF; wstrb = 4'hF; wvalid = 1'b1;
        expect_wr(32'h1000_0004, 32'hDEAD_BEEF, 4'hF);
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        chk("t1_awready_drop", 32'(awready), 0);
        chk("t1_wready_drop", 32'(wready), 0);
        chk("t1_no_psel_n", 32'(psel), 0);
        step();
        chk("t1_setup_psel", 32'(psel), 1);
        chk("t1_setup_penable", 32'(penable), 0);
        step();
        chk("t1_access_psel", 32'(psel), 1);
        chk("t1_access_penable", 32'(penable), 1);
        step();
        chk("t1_bvalid_n3", 32'(bvalid), 1);
        chk("t1_bresp", 32'(bresp), 0);
        chk("t1_psel_drop", 32'(psel), 0);
        step();
        chk("t1_bvalid_drop", 32'(bvalid), 0);
        chk("t1_awready_back", 32'(awready), 1);
        chk("t1_wready_back", 32'(wready), 1);

        // W three edges ahead of AW
        wdata = 32'hA5A5_0001; wstrb = 4'h3; wvalid = 1'b1;
        step();
        wvalid = 1'b0;
        chk("t2_wready_drop", 32'(wready), 0);
        chk("t2_awready_high", 32'(awready), 1);
        step();
        chk("t2_no_psel_1", 32'(psel), 0);
        step();
        chk("t2_no_psel_2", 32'(psel), 0);
        awaddr = 32'h1000_0008; awvalid = 1'b1;
        expect_wr(32'h1000_0008, 32'hA5A5_0001, 4'h3);
        step();
        awvalid = 1'b0;
        chk("t2_no_psel_n", 32'(psel), 0);
        step();
        chk("t2_setup", 32'(psel && !penable), 1);
        step();
        chk("t2_access", 32'(psel && penable), 1);
        step();
        chk("t2_bvalid", 32'(bvalid), 1);
        chk("t2_bresp", 32'(bresp), 0);
        step();

        // Read with two wait states
        slv_wait = 2; slv_rdata = 32'h1234_5678;
        araddr = 32'h2000_0000; arvalid = 1'b1;
        expect_rd(32'h2000_0000);
        step();
        arvalid = 1'b0;
        chk("t3_arready_drop", 32'(arready), 0);
        step();
        chk("t3_setup", 32'(psel && !penable), 1);
        chk("t3_pstb", 32'(pstb), 0);
        chk("t3_pwrite", 32'(pwrite), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t3_access", 32'(psel && penable), 1);
            chk("t3_no_rvalid", 32'(rvalid), 0);
        end
        step();
        chk("t3_rvalid_n5", 32'(rvalid), 1);
        chk("t3_rdata", rdata, 32'h1234_5678);
        chk("t3_rresp", 32'(rresp), 0);
        step();
        chk("t3_rvalid_drop", 32'(rvalid), 0);
        chk("t3_arready_back", 32'(arready), 1);

        // Round-robin arbitration from a fresh reset
        do_reset();
        slv_wait = 0; slv_err = 1'b0; slv_rdata = 32'h0BAD_F00D;
        both_round("arb1", 32'h1000_0010, 32'h1111_2222, 32'h2000_0010, 1'b1);
        both_round("arb2", 32'h1000_0014, 32'h3333_4444, 32'h2000_0014, 1'b0);

        // Slave error on a write
        slv_wait = 1; slv_err = 1'b1;
        awaddr = 32'h1000_0020; awvalid = 1'b1;
        wdata = 32'h0000_00FF; wstrb = 4'h1; wvalid = 1'b1;
        expect_wr(32'h1000_0020, 32'h0000_00FF, 4'h1);
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        wait_for("t5_bvalid", 0);
        chk("t5_bresp_slverr", 32'(bresp), 32'h2);
        wait_for("t5_idle", 3);
        slv_err = 1'b0;

        // Read timeout after TO ACCESS cycles
        slv_wait = 100; slv_rdata = 32'hCAFE_F00D;
        araddr = 32'h2000_0040; arvalid = 1'b1;
        expect_rd(32'h2000_0040);
        step();
        arvalid = 1'b0;
        step();
        chk("t6_setup", 32'(psel && !penable), 1);
        for (int i = 0; i < int'(TO); i++) begin
            step();
            chk("t6_access", 32'(psel && penable), 1);
        end
        step();
        chk("t6_psel_drop", 32'(psel), 0);
        chk("t6_rvalid", 32'(rvalid), 1);
        chk("t6_rresp", 32'(rresp), 32'h3);
        chk("t6_rdata", rdata, 0);
        wait_for("t6_idle", 3);

        // BREADY back-pressure
        slv_wait = 0;
        bready = 1'b0;
        awaddr = 32'h1000_0030; awvalid = 1'b1;
        wdata = 32'h5555_AAAA; wstrb = 4'hC; wvalid = 1'b1;
        expect_wr(32'h1000_0030, 32'h5555_AAAA, 4'hC);
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        wait_for("t7_bvalid", 0);
        for (int i = 0; i < 5; i++) begin
            chk("t7_bvalid_held", 32'(bvalid), 1);
            chk("t7_bresp_held", 32'(bresp), 0);
            chk("t7_awready_low", 32'(awready), 0);
            step();
        end
        bready = 1'b1;
        step();
        chk("t7_bvalid_drop", 32'(bvalid), 0);
        chk("t7_awready_back", 32'(awready), 1);

        // Reset while a write sits in ACCESS
        slv_wait = 3;
        awaddr = 32'h1000_0050; awvalid = 1'b1;
        wdata = 32'h7777_8888; wstrb = 4'hF; wvalid = 1'b1;
        expect_wr(32'h1000_0050, 32'h7777_8888, 4'hF);
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        wait_for("t8_access", 2);
        rst = 1'b1;
        flush_model();
        #1;
        chk("t8_psel_rst", 32'(psel), 0);
        chk("t8_penable_rst", 32'(penable), 0);
        chk("t8_bvalid_rst", 32'(bvalid), 0);
        chk("t8_rvalid_rst", 32'(rvalid), 0);
        chk("t8_awready_rst", 32'(awready), 0);
        step();
        rst = 1'b0;
        step();
        chk("t8_awready_rel", 32'(awready), 1);
        chk("t8_wready_rel", 32'(wready), 1);
        chk("t8_arready_rel", 32'(arready), 1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t8_no_bvalid", 32'(bvalid), 0);
            chk("t8_no_psel", 32'(psel), 0);
        end

        chk("apb_queue_drained", 32'(exp_apb.size()), 0);
        chk("b_queue_drained", 32'(exp_b.size()), 0);
        chk("r_queue_drained", 32'(exp_r.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
